// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write bus driven by the UART program loader.
// master = loader side, slave = memory side.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;

    modport master (output imem_we_o, output imem_addr_o, output imem_wdata_o);
    modport slave  (input  imem_we_o, input  imem_addr_o, input  imem_wdata_o);
endinterface

// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver that assembles little-endian 32-bit words and writes them
// to instruction memory until END_WORD arrives, holding the core in reset meanwhile.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                rx_i,
    uart_prog_loader_if.master  imem,
    output logic                core_rst_o,
    output logic                prog_done_o,
    output logic                frame_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              core_rst_q, core_rst_d;
    logic              ferr_q, ferr_d;
    logic              byte_valid;
    logic [31:0]       full_word;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_q       <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_q       <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_q;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
                    if (rx_q) byte_valid = 1'b1;
                    else      ferr_d     = ~done_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // byte_valid is combinational on the stop-bit sample so the write lands one cycle later
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        core_rst_d = core_rst_q;
        full_word  = {shift_q, word_q[23:0]};

        if (we_q) addr_d = addr_q + 1'b1;

        if (byte_valid && !done_q) begin
            if (byte_cnt_q == 2'd3) begin
                byte_cnt_d = '0;
                if (full_word != END_WORD) begin
                    we_d    = 1'b1;
                    wdata_d = full_word;
                end else begin
                    done_d     = 1'b1;
                    core_rst_d = 1'b0;
                end
            end else begin
                word_d[8*byte_cnt_q +: 8] = shift_q;
                byte_cnt_d                = byte_cnt_q + 1'b1;
            end
        end
    end

    assign imem.imem_we_o    = we_q;
    assign imem.imem_addr_o  = addr_q;
    assign imem.imem_wdata_o = wdata_q;
    assign core_rst_o        = core_rst_q;
    assign prog_done_o       = done_q;
    assign frame_err_o       = ferr_q;
endmodule
